// File: rtl/gnr_pkg.sv
// Shared definitions for the attractor search controller.
//   state_t   : controller FSM state encoding
//   CNT_W_DEF : default width of the step and period counters
package gnr_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        RUN    = 3'd2,
        PERIOD = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/gnr_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count enable; holds at all-ones instead of wrapping
//   cnt      : current count
module gnr_sat_counter
    import gnr_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && (cnt != '1))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Attractor search controller for a Boolean network held as two copies
// (slow s0, fast s1). The nodes are re-initialised, then both copies run
// until they agree (transient length), then only the fast copy runs until
// it agrees with the frozen slow copy again (cycle length).
//   start/init_vec/max_steps : search request, sampled in IDLE
//   s0_vec/s1_vec            : current node values of the two copies
//   reset_nos/init_state     : node re-initialise strobe and value
//   start_s0/start_s1        : advance enables for the two copies
//   busy                     : search in progress (any state but IDLE)
//   res_*                    : result, valid/ready handshake
module gnr_attractor_ctrl
    import gnr_pkg::*;
#(
    parameter int NODES = 8,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NODES-1:0] init_vec,
    input  logic [CNT_W-1:0] max_steps,
    input  logic [NODES-1:0] s0_vec,
    input  logic [NODES-1:0] s1_vec,
    output logic             reset_nos,
    output logic [NODES-1:0] init_state,
    output logic             start_s0,
    output logic             start_s1,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_steps,
    output logic [CNT_W-1:0] res_period,
    output logic [NODES-1:0] res_state,
    output logic             res_timeout
);

    state_t           state, state_n;
    logic [CNT_W-1:0] step_cnt, period_cnt, max_q;
    logic             meet_run, meet_per, step_to, per_to;

    // Count 0 is excluded: both copies trivially agree before any advance.
    assign meet_run = (step_cnt != '0) && (s0_vec == s1_vec);
    assign meet_per = (period_cnt != '0) && (s1_vec == s0_vec);
    assign step_to  = (step_cnt == max_q);
    assign per_to   = (period_cnt == max_q);

    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);

    gnr_sat_counter #(.W(CNT_W)) u_step_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state == INIT),
        .en  (state == RUN),
        .cnt (step_cnt)
    );

    // Held clear throughout RUN, so it starts from 0 on the first PERIOD cycle.
    gnr_sat_counter #(.W(CNT_W)) u_period_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state == RUN),
        .en  (state == PERIOD),
        .cnt (period_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = INIT;
            INIT:    state_n = RUN;
            RUN: begin
                // meet wins over a simultaneous budget expiry
                if (meet_run)     state_n = PERIOD;
                else if (step_to) state_n = DONE;
            end
            PERIOD:  if (meet_per || per_to) state_n = DONE;
            DONE:    if (res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Node controls are decoded from the next state so they line up with
    // the state register while still coming straight out of flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reset_nos <= 1'b0;
            start_s0  <= 1'b0;
            start_s1  <= 1'b0;
        end else begin
            reset_nos <= (state_n == INIT);
            start_s0  <= (state_n == RUN);
            start_s1  <= (state_n == RUN) || (state_n == PERIOD);
        end
    end

    // Request capture and result latching. Results are cleared when a new
    // search is accepted so a timeout never carries stale state/period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_state  <= '0;
            max_q       <= '0;
            res_steps   <= '0;
            res_period  <= '0;
            res_state   <= '0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        init_state  <= init_vec;
                        max_q       <= max_steps;
                        res_steps   <= '0;
                        res_period  <= '0;
                        res_state   <= '0;
                        res_timeout <= 1'b0;
                    end
                end
                RUN: begin
                    if (meet_run) begin
                        res_steps <= step_cnt;
                        res_state <= s0_vec;
                    end else if (step_to) begin
                        res_timeout <= 1'b1;
                        res_steps   <= max_q;
                        res_period  <= '0;
                    end
                end
                PERIOD: begin
                    if (meet_per) begin
                        res_period <= period_cnt;
                    end else if (per_to) begin
                        res_timeout <= 1'b1;
                        res_period  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl. A small 4-node network model sits on the
// node side: re-init loads the slow copy with init_state and the fast copy
// two steps ahead; each enable advances its copy by one step. Expected
// results come from a software walk of the same network and are queued
// when a search is launched, then popped when res_valid appears.
module tb_gnr_attractor_ctrl;

    localparam int N  = 4;
    localparam int CW = 16;

    typedef struct {
        logic [CW-1:0] steps;
        logic [CW-1:0] period;
        logic [N-1:0]  state;
        logic          timeout;
    } res_t;

    logic          clk = 1'b0;
    logic          rst, start, res_ready;
    logic [N-1:0]  init_vec;
    logic [CW-1:0] max_steps;
    logic [N-1:0]  s0_vec = '0, s1_vec = '0;
    logic          reset_nos, start_s0, start_s1, busy, res_valid, res_timeout;
    logic [N-1:0]  init_state, res_state;
    logic [CW-1:0] res_steps, res_period;

    int   net = 0;
    int   n_chk = 0, n_fail = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    gnr_attractor_ctrl #(.NODES(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .init_vec(init_vec),
        .max_steps(max_steps), .s0_vec(s0_vec), .s1_vec(s1_vec),
        .reset_nos(reset_nos), .init_state(init_state),
        .start_s0(start_s0), .start_s1(start_s1), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_steps(res_steps), .res_period(res_period),
        .res_state(res_state), .res_timeout(res_timeout)
    );

    // 0: fixed point, 1: toggle, 2: 4-state ring, 3: rotate-by-2 (period 2)
    function automatic logic [N-1:0] f_net(input int n, input logic [N-1:0] s);
        case (n)
            1:       return ~s;
            2:       return {s[2:0], s[3]};
            3:       return {s[1:0], s[3:2]};
            default: return s;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset_nos) begin
            s0_vec <= init_state;
            s1_vec <= f_net(net, f_net(net, init_state));
        end else begin
            if (start_s0) s0_vec <= f_net(net, s0_vec);
            if (start_s1) s1_vec <= f_net(net, s1_vec);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Walk the network step by step as the search is defined to behave.
    task automatic ref_model(input int n, input logic [N-1:0] x,
                             input logic [CW-1:0] m, output res_t r);
        logic [N-1:0] a, b;
        bit met;
        int k, p;
        r = '{steps: '0, period: '0, state: '0, timeout: 1'b0};
        a = x; b = f_net(n, f_net(n, x)); met = 0;
        for (k = 0; k <= 1000; k++) begin
            if (k >= 1 && a == b) begin
                r.steps = CW'(k); r.state = a; met = 1; break;
            end
            if (k == int'(m)) begin
                r.timeout = 1'b1; r.steps = m; r.period = '0; break;
            end
            a = f_net(n, a); b = f_net(n, b);
        end
        if (met) begin
            // both copies still advance on the edge that ends the meet cycle
            a = f_net(n, a); b = f_net(n, b);
            for (p = 0; p <= 1000; p++) begin
                if (p >= 1 && a == b) begin r.period = CW'(p); break; end
                if (p == int'(m)) begin r.timeout = 1'b1; r.period = '0; break; end
                b = f_net(n, b);
            end
        end
    endtask

    task automatic run_search(input int n, input logic [N-1:0] x, input logic [CW-1:0] m,
                              input int hold, input bit poke);
        res_t e;
        int cyc;
        ref_model(n, x, m, e);
        sb.push_back(e);
        net = n;
        @(negedge clk); init_vec = x; max_steps = m; start = 1'b1;
        @(negedge clk); start = 1'b0; init_vec = ~x; max_steps = '1;
        chk("init_reset_nos", reset_nos, 1);
        chk("init_state", init_state, x);
        chk("init_start_s0", start_s0, 0);
        chk("init_start_s1", start_s1, 0);
        chk("init_busy", busy, 1);
        @(negedge clk);
        chk("run_reset_nos", reset_nos, 0);
        chk("run_start_s0", start_s0, 1);
        chk("run_start_s1", start_s1, 1);
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < 200) begin
            start = poke & start_s1;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("res_valid_seen", res_valid, 1);
        e = sb.pop_front();
        for (int h = 0; h <= hold; h++) begin
            chk("res_valid_hold", res_valid, 1);
            chk("res_steps", res_steps, e.steps);
            chk("res_period", res_period, e.period);
            chk("res_state", res_state, e.state);
            chk("res_timeout", res_timeout, e.timeout);
            chk("done_start_s1", start_s1, 0);
            if (h < hold) @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk); res_ready = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_res_valid", res_valid, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_reset_nos"}, reset_nos, 0);
        chk({tag, "_start_s0"}, start_s0, 0);
        chk({tag, "_start_s1"}, start_s1, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_steps"}, res_steps, 0);
        chk({tag, "_res_period"}, res_period, 0);
        chk({tag, "_res_state"}, res_state, 0);
        chk({tag, "_res_timeout"}, res_timeout, 0);
        chk({tag, "_init_state"}, init_state, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; res_ready = 1'b0;
        init_vec = '0; max_steps = '0;
        #3 chk_zero("reset");
        @(negedge clk); @(negedge clk); rst = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("idle_after_reset", busy, 0);

        run_search(0, 4'b0001, 16'd10, 5, 1'b0);  // fixed point: 1/1, stalled ready
        run_search(1, 4'b0000, 16'd10, 0, 1'b0);  // toggle: steps 1, period 2
        run_search(2, 4'b0001, 16'd2,  0, 1'b0);  // ring: timeout in RUN at 2
        run_search(2, 4'b0001, 16'd0,  0, 1'b0);  // zero budget: immediate timeout
        run_search(1, 4'b0101, 16'd1,  2, 1'b0);  // meet beats budget, then PERIOD timeout
        run_search(3, 4'b0011, 16'd10, 0, 1'b1);  // start pokes in RUN/PERIOD ignored
        run_search(1, 4'b1100, 16'd10, 0, 1'b1);

        // abort a ring search at step_cnt == 3
        net = 2;
        @(negedge clk); init_vec = 4'b0001; max_steps = 16'd10; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_in_run", start_s0, 1);
        #2 rst = 1'b1;
        #1 chk_zero("abort");
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_result", res_valid, 0);
        chk("abort_idle", busy, 0);
        run_search(2, 4'b0001, 16'd10, 0, 1'b0);  // clean rerun after abort

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
